sram_burst_seq: RTL

Burst sequencer directly upstream of the 1Mx8 SRAM controller. It accepts burst commands (start address, length, read/write) from the application side and converts them into single-byte req/ack transactions on the controller's request port. Write data streams in and read data streams out over valid/ready handshakes. Every burst ends with a one-cycle done pulse.

---
 rtl/sram_burst_seq_pkg.sv | 18 +
 rtl/sram_addr_ctr.sv | 45 ++++
 rtl/sram_burst_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sram_burst_seq_pkg.sv
// Shared SRAM geometry and sequencer state encoding for sram_burst_seq.
package sram_burst_seq_pkg;

   localparam int          SRAM_ADDR_W = 20;
   localparam int          SRAM_DATA_W = 8;
   localparam int          SRAM_LEN_W  = 8;
   // Byte capacity of the 1Mx8 array; the controller sizes itself from this too.
   localparam int unsigned SRAM_SIZE   = 32'd1 << SRAM_ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_WDATA = 3'd1,
      ST_MEM_REQ    = 3'd2,
      ST_RD_HOLD    = 3'd3,
      ST_DONE       = 3'd4
   } seq_state_e;

endpackage

// File: rtl/sram_addr_ctr.sv
// Loadable wrapping byte-address register plus remaining-count down-counter.
module sram_addr_ctr #(
   parameter int ADDR_W = 20,
   parameter int LEN_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [LEN_W-1:0]  i_load_len,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;

   // Address increment wraps naturally at 2^ADDR_W.
   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (i_load) begin
         addr_d = i_load_addr;
         rem_d  = i_load_len;
      end else if (i_step) begin
         addr_d = addr_q + ADDR_W'(1);
         rem_d  = rem_q - LEN_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign o_addr = addr_q;
   assign o_last = (rem_q == '0);

endmodule

// File: rtl/sram_burst_seq.sv
// Burst sequencer: splits burst commands into single-byte SRAM controller requests.
// Define SRAM_SEQ_CKSUM_EN to add o_cksum, the running XOR of the burst's bytes.
module sram_burst_seq
   import sram_burst_seq_pkg::*;
#(
   parameter int ADDR_W = $clog2(SRAM_SIZE),
   parameter int DATA_W = SRAM_DATA_W,
   parameter int LEN_W  = SRAM_LEN_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic              i_wdata_valid,
   output logic              o_wdata_ready,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_rdata_valid,
   input  logic              i_rdata_ready,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic              o_done
`ifdef SRAM_SEQ_CKSUM_EN
  ,output logic [DATA_W-1:0] o_cksum
`endif
);

   seq_state_e        state_q;
   logic              cmd_ready_q, wdata_ready_q, rdata_valid_q;
   logic              mem_req_q, mem_we_q, busy_q, done_q;
   logic [DATA_W-1:0] rdata_q, mem_wdata_q;
   logic              accept, step, last;
`ifdef SRAM_SEQ_CKSUM_EN
   logic [DATA_W-1:0] cksum_q;
`endif

   assign accept = (state_q == ST_IDLE) && cmd_ready_q && i_cmd_valid;
   assign step   = ((state_q == ST_MEM_REQ) && i_mem_ack && mem_we_q && !last) ||
                   ((state_q == ST_RD_HOLD) && i_rdata_ready && !last);

   sram_addr_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ctr (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_load      (accept),
      .i_load_addr (i_cmd_addr),
      .i_load_len  (i_cmd_len),
      .i_step      (step),
      .o_addr      (o_mem_addr),
      .o_last      (last)
   );

   // Output flags are set alongside the transition into the state that owns them.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b0;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
`ifdef SRAM_SEQ_CKSUM_EN
         cksum_q       <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!cmd_ready_q) begin
                  cmd_ready_q <= 1'b1;
               end else if (i_cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  mem_we_q    <= i_cmd_write;
`ifdef SRAM_SEQ_CKSUM_EN
                  cksum_q     <= '0;
`endif
                  if (i_cmd_write) begin
                     wdata_ready_q <= 1'b1;
                     state_q       <= ST_WAIT_WDATA;
                  end else begin
                     mem_req_q <= 1'b1;
                     state_q   <= ST_MEM_REQ;
                  end
               end
            end
            ST_WAIT_WDATA: begin
               if (i_wdata_valid) begin
                  mem_wdata_q   <= i_wdata;
                  wdata_ready_q <= 1'b0;
                  mem_req_q     <= 1'b1;
`ifdef SRAM_SEQ_CKSUM_EN
                  cksum_q       <= cksum_q ^ i_wdata;
`endif
                  state_q       <= ST_MEM_REQ;
               end
            end
            ST_MEM_REQ: begin
               if (i_mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (!mem_we_q) begin
                     rdata_q       <= i_mem_rdata;
                     rdata_valid_q <= 1'b1;
`ifdef SRAM_SEQ_CKSUM_EN
                     cksum_q       <= cksum_q ^ i_mem_rdata;
`endif
                     state_q       <= ST_RD_HOLD;
                  end else if (last) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     wdata_ready_q <= 1'b1;
                     state_q       <= ST_WAIT_WDATA;
                  end
               end
            end
            ST_RD_HOLD: begin
               if (i_rdata_ready) begin
                  rdata_valid_q <= 1'b0;
                  if (last) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     mem_req_q <= 1'b1;
                     state_q   <= ST_MEM_REQ;
                  end
               end
            end
            ST_DONE: begin
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_cmd_ready   = cmd_ready_q;
   assign o_wdata_ready = wdata_ready_q;
   assign o_rdata_valid = rdata_valid_q;
   assign o_rdata       = rdata_q;
   assign o_mem_req     = mem_req_q;
   assign o_mem_we      = mem_we_q;
   assign o_mem_wdata   = mem_wdata_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
`ifdef SRAM_SEQ_CKSUM_EN
   assign o_cksum       = cksum_q;
`endif

endmodule
